// File: rtl/lcd_pkg.sv
// Shared LCD-path definitions: button FSM states and default debounce/repeat timing.
package lcd_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REPEAT_CYCLES_DEF   = 25000000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_fsm_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, parameterized by width.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/btn_prell_block.sv
// Debounced write pushbutton: captures the character switches on an accepted press
// and strobes prell_flag. Define BTN_AUTO_REPEAT_EN for periodic re-capture while held.
module btn_prell_block
    import lcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_in,
    input  logic [7:0] sw_in,
    output logic [7:0] data_btn,
    output logic       prell_flag,
    output logic       btn_state
);

    localparam int CNT_W = $clog2(max_i(DEBOUNCE_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       w_btn_sync;
    logic [7:0] w_sw_sync;

    btn_fsm_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic             r_flag;
    logic             r_btn_state;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (btn_in),
        .o_q     (w_btn_sync)
    );

    sync_2ff #(.WIDTH(8)) u_sync_sw (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (sw_in),
        .o_q     (w_sw_sync)
    );

    // The all-ones guard keeps cnt saturating even if a state is entered unexpectedly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data      <= 8'h00;
            r_flag      <= 1'b0;
            r_btn_state <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_sync) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
                        r_data      <= w_sw_sync;
                        r_flag      <= 1'b1;
                        r_btn_state <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_btn_sync) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                        r_cnt  <= '0;
                        r_data <= w_sw_sync;
                        r_flag <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // A high sample here is release bounce: back to PRESSED, no new strobe.
                    if (w_btn_sync) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_btn_state <= 1'b0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_btn   = r_data;
    assign prell_flag = r_flag;
    assign btn_state  = r_btn_state;

endmodule

// File: tb/tb_btn_prell_block.sv
// Scoreboard bench for btn_prell_block with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_btn_prell_block;
    import lcd_pkg::*;

    localparam int DEB = 4;
    localparam int REP = 10;
    localparam int LAT = DEB + 3;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_in;
    logic [7:0] sw_in;
    logic [7:0] data_btn;
    logic       prell_flag;
    logic       btn_state;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic prev_flag = 1'b0;

    btn_prell_block #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .data_btn   (data_btn),
        .prell_flag (prell_flag),
        .btn_state  (btn_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int at, input logic [7:0] d);
        exp_t e;
        e.cyc  = at;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Strobe monitor: every prell_flag must match the head of the scoreboard.
    always @(negedge clk) begin
        if (prell_flag) begin
            if (prev_flag) chk("flag_back2back", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_data", {24'd0, data_btn}, {24'd0, e.data});
            end
        end
        prev_flag <= prell_flag;
    end

    initial begin
        int n;
        reset_n = 1'b0;
        btn_in  = 1'b0;
        sw_in   = 8'h00;
        tick(3);
        chk("rst_data", {24'd0, data_btn}, 32'h00);
        chk("rst_flag", {31'd0, prell_flag}, 32'd0);
        chk("rst_state", {31'd0, btn_state}, 32'd0);
        reset_n = 1'b1;
        tick(3);

        // Clean press.
        sw_in  = 8'h8C;
        btn_in = 1'b1;
        push_exp(cyc + LAT, 8'h8C);
        tick(LAT - 1);
        chk("press_state_early", {31'd0, btn_state}, 32'd0);
        tick(3);
        chk("press_state", {31'd0, btn_state}, 32'd1);
        chk("press_data", {24'd0, data_btn}, 32'h8C);

        // Release with 2-clock bounces.
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0;
        tick(LAT - 1);
        chk("rel_state_held", {31'd0, btn_state}, 32'd1);
        tick(1);
        chk("rel_state_fall", {31'd0, btn_state}, 32'd0);
        chk("rel_data_hold", {24'd0, data_btn}, 32'h8C);
        tick(3);

        // 3-clock glitch.
        sw_in  = 8'h55;
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0;
        tick(10);
        chk("glitch_data", {24'd0, data_btn}, 32'h8C);
        chk("glitch_fsm", int'(dut.r_state), int'(IDLE));
        chk("glitch_state", {31'd0, btn_state}, 32'd0);

        // Reset 2 clocks into PRESS_WAIT, button held across reset.
        sw_in  = 8'h3A;
        btn_in = 1'b1;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        chk("midrst_data", {24'd0, data_btn}, 32'h00);
        chk("midrst_flag", {31'd0, prell_flag}, 32'd0);
        chk("midrst_state", {31'd0, btn_state}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        push_exp(cyc + LAT, 8'h3A);
        tick(LAT + 2);
        chk("postrst_data", {24'd0, data_btn}, 32'h3A);
        chk("postrst_state", {31'd0, btn_state}, 32'd1);

        // Switch change while held.
        btn_in = 1'b0;
        tick(12);
        sw_in  = 8'h8C;
        btn_in = 1'b1;
        n = cyc;
        push_exp(n + LAT, 8'h8C);
`ifdef BTN_AUTO_REPEAT_EN
        push_exp(n + LAT + REP, 8'h41);
        push_exp(n + LAT + 2 * REP, 8'h41);
        push_exp(n + LAT + 3 * REP, 8'h41);
`endif
        tick(9);
        sw_in = 8'h41;
        tick(31);
`ifdef BTN_AUTO_REPEAT_EN
        chk("held_data", {24'd0, data_btn}, 32'h41);
`else
        chk("held_data", {24'd0, data_btn}, 32'h8C);
`endif
        btn_in = 1'b0;
        tick(12);
        chk("held_rel_state", {31'd0, btn_state}, 32'd0);
`ifdef BTN_AUTO_REPEAT_EN
        chk("held_rel_data", {24'd0, data_btn}, 32'h41);
`else
        chk("held_rel_data", {24'd0, data_btn}, 32'h8C);
`endif

        tick(3);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_prell_block.md
BTN_PRELL_BLOCK -- requirements
Module: btn_prell_block

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable samples required before a level change is accepted (10 ms at 50 MHz); minimum legal value 2.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 25000000, the auto-repeat period in clocks; it is used only when BTN_AUTO_REPEAT_EN is defined.
REQ-003 Port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port btn_in, input, 1 bit: raw, bouncing, asynchronous write pushbutton; high means pressed.
REQ-006 Port sw_in, input, 8 bits: raw, asynchronous character switches.
REQ-007 Port data_btn, output, 8 bits: the character byte captured on an accepted press, to write_lcd_block.
REQ-008 Port prell_flag, output, 1 bit: one-cycle strobe marking data_btn as new and valid, to write_lcd_block.
REQ-009 Port btn_state, output, 1 bit: the debounced button level.

Function
REQ-010 btn_in and sw_in SHALL each pass through a 2-FF synchronizer; btn_sync and sw_sync denote the second-stage outputs.
REQ-011 The FSM SHALL have states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter cnt of width clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)).
REQ-012 IDLE SHALL go to PRESS_WAIT with cnt=0 when btn_sync=1, and otherwise stay in IDLE.
REQ-013 PRESS_WAIT, when btn_sync=1, SHALL increment cnt.
REQ-014 PRESS_WAIT, when btn_sync=1 and cnt==DEBOUNCE_CYCLES-1, SHALL go to PRESSED, load data_btn<=sw_sync, drive prell_flag<=1 and set btn_state<=1.
REQ-015 PRESS_WAIT, when btn_sync=0, SHALL return to IDLE with no strobe.
REQ-016 PRESSED SHALL go to RELEASE_WAIT with cnt=0 when btn_sync=0.
REQ-017 RELEASE_WAIT SHALL count stable-low samples and go to IDLE with btn_state<=0 when btn_sync=0 and cnt==DEBOUNCE_CYCLES-1.
REQ-018 RELEASE_WAIT SHALL return to PRESSED with no new strobe when btn_sync=1 (bounce on release).
REQ-019 prell_flag SHALL be registered and high for exactly one clock per accepted event.
REQ-020 prell_flag SHALL never be high on two consecutive clocks.
REQ-021 Latency from btn_in rising and staying high to prell_flag high SHALL be exactly DEBOUNCE_CYCLES+3 rising edges.
REQ-022 data_btn SHALL change only in the cycle prell_flag rises, and SHALL hold its value otherwise, including through release and IDLE.
REQ-023 A bounce pulse shorter than DEBOUNCE_CYCLES samples SHALL produce no strobe and SHALL leave data_btn unchanged.
REQ-024 A change on sw_in while the button is held SHALL NOT alter data_btn, except by an auto-repeat capture (REQ-029).
REQ-025 cnt SHALL saturate and SHALL never wrap while in any counting state.

Reset
REQ-026 While reset_n=0, the block SHALL hold state=IDLE, cnt=0, data_btn=8'h00, prell_flag=0, btn_state=0 and all synchronizer flops at 0.
REQ-027 Reset asserted mid-debounce or while PRESSED SHALL abort with no strobe; after release of reset the button must be seen pressed again from IDLE.
REQ-028 A button already held when reset_n releases SHALL be accepted after DEBOUNCE_CYCLES+3 edges as a fresh press.

Configuration
REQ-029 With BTN_AUTO_REPEAT_EN defined, PRESSED SHALL count held cycles; when cnt==REPEAT_CYCLES-1 it SHALL re-capture data_btn<=sw_sync, pulse prell_flag for one clock, clear cnt and repeat every REPEAT_CYCLES while held.
REQ-030 With BTN_AUTO_REPEAT_EN undefined, the block SHALL emit exactly one strobe per accepted press, and REPEAT_CYCLES SHALL be unused.

Structure
REQ-031 The state enum and the default DEBOUNCE_CYCLES/REPEAT_CYCLES constants SHALL reside in shared package lcd_pkg, which write_lcd_block also imports.
REQ-032 The synchronizer SHALL be sub-module sync_2ff, parameterized by width and instantiated twice (width 1 and width 8).

Verification
REQ-033 The bench SHALL cover, with DEBOUNCE_CYCLES=4:
- sw_in=8'h8C, btn_in high and held -> prell_flag high for exactly one clock 7 edges later, data_btn=8'h8C.
- btn_in 3-clock glitch -> no prell_flag, data_btn unchanged, state back to IDLE.
- Release with 2-clock bounces, then a stable low -> no extra strobe; btn_state falls 7 edges after the last bounce ends.
- reset_n pulled low 2 clocks into PRESS_WAIT -> all outputs 0, no strobe; held button re-accepted 7 edges after reset_n release.
- sw_in changed 8'h8C->8'h41 while held, auto-repeat off -> data_btn stays 8'h8C.
- sw_in changed 8'h8C->8'h41 while held, BTN_AUTO_REPEAT_EN with REPEAT_CYCLES=10 -> strobes every 10 clocks, data_btn=8'h41 after the first repeat.
